// File: rtl/bdm_sync_engine_if.sv
// Handshake and pad signals between the BDM command sequencer (master)
// and the SYNC measurement engine (slave).
interface bdm_sync_engine_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             bkgd_in;
    logic             bkgd_oe;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] sync_len;
    logic             sync_valid;

    modport slave (
        input  start, abort, bkgd_in,
        output bkgd_oe, busy, done, error, err_code, sync_len, sync_valid
    );

    modport master (
        output start, abort, bkgd_in,
        input  bkgd_oe, busy, done, error, err_code, sync_len, sync_valid
    );
endinterface

// File: rtl/bdm_sync_engine.sv
// BDM SYNC measurement engine: drives BKGD low, times the target's low
// response over 2**LOG2_N samples and reports the truncated average.
module bdm_sync_engine #(
    parameter int CNT_W    = 16,
    parameter int SYNC_LOW = 6500,
    parameter int SETTLE   = 15,
    parameter int TIMEOUT  = 4000,
    parameter int LOG2_N   = 2
) (
    input  logic             clk,
    input  logic             rst,
    bdm_sync_engine_if.slave bus
);
    localparam int ACC_W = CNT_W + LOG2_N;
    localparam int IDX_W = (LOG2_N > 0) ? LOG2_N : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST  = CNT_W'(SYNC_LOW - 32'sd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 32'sd1);
    localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((32'd1 << LOG2_N) - 32'd1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NO_RESP = 2'd1;
    localparam logic [1:0] ERR_STUCK   = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRIVE    = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_COUNT    = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic             bk_meta_q, bk_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             bkgd_oe_q, bkgd_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] sync_len_q, sync_len_d;
    logic             sync_valid_q, sync_valid_d;

    logic             fail_s;
    logic [1:0]       fail_code_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic             measuring_s;

    // Two-flop synchroniser; the idle line level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            bk_meta_q <= 1'b1;
            bk_s_q    <= 1'b1;
        end else begin
            bk_meta_q <= bus.bkgd_in;
            bk_s_q    <= bk_meta_q;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        err_code_d   = err_code_q;
        sync_len_d   = sync_len_q;
        sync_valid_d = sync_valid_q;
        fail_s       = 1'b0;
        fail_code_s  = ERR_OK;
        acc_sum_s    = acc_q + ACC_W'(cnt_q);
        measuring_s  = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                       (state_q == ST_WAIT_LOW) || (state_q == ST_COUNT);

        if (bus.abort && measuring_s) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_ABORT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d      = ST_DRIVE;
                        cnt_d        = '0;
                        idx_d        = '0;
                        acc_d        = '0;
                        sync_valid_d = 1'b0;
                        err_code_d   = ERR_OK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!bk_s_q) begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == TMO_LIMIT) begin
                        fail_s      = 1'b1;
                        fail_code_s = ERR_NO_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_COUNT: begin
                    if (bk_s_q) begin
                        acc_d = acc_sum_s;
                        if (idx_q == IDX_LAST) begin
                            state_d      = ST_DONE;
                            done_d       = 1'b1;
                            sync_len_d   = CNT_W'(acc_sum_s >> LOG2_N);
                            sync_valid_d = 1'b1;
                            err_code_d   = ERR_OK;
                        end else begin
                            state_d = ST_DRIVE;
                            idx_d   = idx_q + IDX_ONE;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q == '1) begin
                        // Saturate rather than wrap: a held-low line is a fault.
                        fail_s      = 1'b1;
                        fail_code_s = ERR_STUCK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (fail_s) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            error_d    = 1'b1;
            err_code_d = fail_code_s;
        end else begin
            error_d = 1'b0;
        end

        busy_d    = (state_d != ST_IDLE);
        bkgd_oe_d = (state_d == ST_DRIVE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            bkgd_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= ERR_OK;
            sync_len_q   <= '0;
            sync_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            bkgd_oe_q    <= bkgd_oe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            sync_len_q   <= sync_len_d;
            sync_valid_q <= sync_valid_d;
        end
    end

    assign bus.bkgd_oe    = bkgd_oe_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;
    assign bus.sync_len   = sync_len_q;
    assign bus.sync_valid = sync_valid_q;
endmodule
